baud_ctrl: RTL and testbench
============================

Name: baud_ctrl

Overview:
Programmable baud-tick controller for the UART. It generates the 16x receive oversample tick and the 1x transmit bit tick from the system clock (75 MHz nominal). The divisor can be changed at runtime through a valid/ready config port. A change is applied only on a transmit bit boundary, so an in-flight bit is never stretched or cut. It sits between the system clock domain and the UART tx/rx engines, and replaces fixed-ratio tick generation.

Parameters:
DIV_W, 16, width of divisor register and counters
DEFAULT_DIV, 488, reset divisor (clocks per rx tick; 75 MHz / (9600*16))
OSR, 16, rx ticks per tx tick (oversample ratio), must be >= 2

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_en  input  1  tick generation enable (level)
i_cfg_div  input  DIV_W  requested divisor
i_cfg_valid  input  1  config request valid
o_cfg_ready  output  1  controller can accept config
o_cfg_err  output  1  one-cycle pulse: request rejected
o_rx_tick  output  1  one-cycle pulse every act_div clocks
o_tx_tick  output  1  one-cycle pulse every OSR rx ticks
o_act_div  output  DIV_W  divisor currently in effect

Behaviour:
- Reset (async, i_rst=1): state=IDLE; act_div=DEFAULT_DIV; rx_cnt=0; os_cnt=0; o_rx_tick=0; o_tx_tick=0; o_cfg_err=0; o_cfg_ready=1; pending discarded.
- All outputs are registered.
- States:
  - IDLE: i_en=0; counters held at 0; no ticks.
  - RUN: ticking; no change pending.
  - PEND: ticking; new divisor held in pend_div.
- IDLE->RUN when i_en=1 is sampled.
- RUN or PEND -> IDLE when i_en=0 is sampled. Counters clear to 0 and ticks go low on that edge.
- Tick counting, each edge in RUN or PEND:
  - If rx_cnt == act_div-1: rx_cnt<=0 and o_rx_tick<=1. Otherwise rx_cnt++ and o_rx_tick<=0.
  - First o_rx_tick goes high on the act_div-th edge after i_en is first sampled 1. Period is exactly act_div cycles.
- os_cnt increments on each rx wrap and wraps at OSR-1. o_tx_tick<=1 on the same edge as the rx tick that wraps os_cnt. Tx period = act_div*OSR cycles.
- Handshake:
  - o_cfg_ready = 1 in IDLE and RUN, 0 in PEND.
  - A transfer occurs on an edge with i_cfg_valid & o_cfg_ready.
  - i_cfg_valid may be held; a new transfer occurs each ready cycle.
- Validation: i_cfg_div < 2 is rejected. o_cfg_err=1 for one cycle; act_div and state are unchanged.
- Accept in IDLE: act_div<=i_cfg_div on the same edge.
- Accept in RUN: pend_div<=i_cfg_div; state->PEND.
- In PEND, on the edge that asserts o_tx_tick: act_div<=pend_div; state->RUN. Counters wrap to 0 normally, so the next bit uses the new period.
- Accept in RUN on the same edge as a tx tick: the request goes to PEND and is applied at the following tx boundary, not the current one.
- i_en=0 sampled in PEND: act_div<=pend_div immediately; state->IDLE.
- Reset in PEND: the pending divisor is lost; act_div returns to DEFAULT_DIV.
- Runtime change only through the config port; act_div never changes outside the edges defined above.

Optional Feature:
Macro BAUD_CTRL_FRAC_EN.
- Defined:
  - Adds input i_cfg_frac[$clog2(OSR)-1:0], captured alongside i_cfg_div, with pending/apply timing identical to the divisor. Reset value is 0.
  - Within each tx bit, rx ticks with os_cnt < act_frac use a period of act_div+1; the rest use act_div.
  - Tx period = act_div*OSR + act_frac.
- Undefined: the port is absent; every rx period is act_div.

Test Plan:
1. Bench overrides DEFAULT_DIV=4, OSR=16. Assert i_rst mid-cycle -> all outputs 0 immediately, o_act_div=4; release; o_cfg_ready=1.
2. Raise i_en -> first o_rx_tick on the 4th edge, then every 4 cycles; o_tx_tick every 64 cycles, coincident with every 16th rx tick; drop i_en -> ticks stop next edge.
3. In IDLE, send div=10 -> o_act_div=10 next cycle; enable -> rx period 10, tx period 160.
4. RUN with div=4, send div=6 at the 5th rx tick -> o_cfg_ready low until the next o_tx_tick; then rx period 6, tx period 96, ready high again.
5. Send div=1, then div=0 -> o_cfg_err single-cycle pulse each time; o_act_div and tick period unchanged; ready stays 1.
6. With FRAC_EN defined, div=4 and frac=3 -> first 3 rx periods of each bit are 5 cycles, the rest 4; tx period 67. Assert i_rst during PEND -> o_act_div=4, frac=0.

Source files
------------

// File: rtl/baud_ctrl_if.sv
// Config and tick bundle for baud_ctrl. Carries i_cfg_frac only when
// BAUD_CTRL_FRAC_EN is defined.
interface baud_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
);
  localparam int FRAC_W = $clog2(OSR);

  logic             i_en;
  logic [DIV_W-1:0] i_cfg_div;
  logic             i_cfg_valid;
`ifdef BAUD_CTRL_FRAC_EN
  logic [FRAC_W-1:0] i_cfg_frac;
`endif
  logic             o_cfg_ready;
  logic             o_cfg_err;
  logic             o_rx_tick;
  logic             o_tx_tick;
  logic [DIV_W-1:0] o_act_div;

  modport master (
    output i_en, i_cfg_div, i_cfg_valid,
`ifdef BAUD_CTRL_FRAC_EN
    output i_cfg_frac,
`endif
    input  o_cfg_ready, o_cfg_err, o_rx_tick, o_tx_tick, o_act_div
  );

  modport slave (
    input  i_en, i_cfg_div, i_cfg_valid,
`ifdef BAUD_CTRL_FRAC_EN
    input  i_cfg_frac,
`endif
    output o_cfg_ready, o_cfg_err, o_rx_tick, o_tx_tick, o_act_div
  );
endinterface

// File: rtl/baud_ctrl.sv
// Baud tick generator: rx oversample tick and tx bit tick, divisor changes land
// on tx bit boundaries. BAUD_CTRL_FRAC_EN adds a fractional rx-period stretch.
//
// state | meaning
// IDLE  | disabled, counters held at 0, no ticks
// RUN   | ticking, no divisor change pending
// PEND  | ticking, new divisor waiting for the next tx tick
module baud_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 488,
  parameter int OSR         = 16
) (
  input logic        i_clk,
  input logic        i_rst,
  baud_ctrl_if.slave bus
);
  localparam int OS_W = $clog2(OSR);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] rx_cnt;
  logic [DIV_W-1:0] rx_last;
  logic [OS_W-1:0]  os_cnt;
  logic             rx_tick;
  logic             tx_tick;
  logic             cfg_err;
  logic             cfg_ready;
  logic             xfer;
  logic             acc;
  logic             rej;
  logic             rx_wrap;
  logic             tx_wrap;
`ifdef BAUD_CTRL_FRAC_EN
  logic [OS_W-1:0]  act_frac;
  logic [OS_W-1:0]  pend_frac;
`endif

  always_comb begin
    xfer = bus.i_cfg_valid & cfg_ready;
    acc  = xfer && (bus.i_cfg_div >= DIV_W'(2));
    rej  = xfer & ~acc;
`ifdef BAUD_CTRL_FRAC_EN
    // the first act_frac rx ticks of each bit run one clock longer
    rx_last = act_div - DIV_W'(1) + DIV_W'(os_cnt < act_frac);
`else
    rx_last = act_div - DIV_W'(1);
`endif
    rx_wrap = (rx_cnt == rx_last);
    tx_wrap = rx_wrap && (os_cnt == OS_W'(OSR - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      act_div   <= DIV_W'(DEFAULT_DIV);
      pend_div  <= '0;
      rx_cnt    <= '0;
      os_cnt    <= '0;
      rx_tick   <= 1'b0;
      tx_tick   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
`ifdef BAUD_CTRL_FRAC_EN
      act_frac  <= '0;
      pend_frac <= '0;
`endif
    end else begin
      cfg_err <= rej;
      if (!bus.i_en) begin
        state     <= IDLE;
        rx_cnt    <= '0;
        os_cnt    <= '0;
        rx_tick   <= 1'b0;
        tx_tick   <= 1'b0;
        cfg_ready <= 1'b1;
        if (state == PEND) begin
          act_div <= pend_div;
`ifdef BAUD_CTRL_FRAC_EN
          act_frac <= pend_frac;
`endif
        end else if (acc) begin
          act_div <= bus.i_cfg_div;
`ifdef BAUD_CTRL_FRAC_EN
          act_frac <= bus.i_cfg_frac;
`endif
        end
      end else begin
        rx_tick <= rx_wrap;
        tx_tick <= tx_wrap;
        if (rx_wrap) begin
          rx_cnt <= '0;
          os_cnt <= tx_wrap ? '0 : os_cnt + OS_W'(1);
        end else begin
          rx_cnt <= rx_cnt + DIV_W'(1);
        end

        case (state)
          IDLE: begin
            state     <= RUN;
            cfg_ready <= 1'b1;
            if (acc) begin
              act_div <= bus.i_cfg_div;
`ifdef BAUD_CTRL_FRAC_EN
              act_frac <= bus.i_cfg_frac;
`endif
            end
          end
          RUN: begin
            if (acc) begin
              // a request landing on a tx tick waits for the following boundary
              pend_div  <= bus.i_cfg_div;
`ifdef BAUD_CTRL_FRAC_EN
              pend_frac <= bus.i_cfg_frac;
`endif
              state     <= PEND;
              cfg_ready <= 1'b0;
            end else begin
              cfg_ready <= 1'b1;
            end
          end
          PEND: begin
            if (tx_wrap) begin
              act_div   <= pend_div;
`ifdef BAUD_CTRL_FRAC_EN
              act_frac  <= pend_frac;
`endif
              state     <= RUN;
              cfg_ready <= 1'b1;
            end else begin
              cfg_ready <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_cfg_ready = cfg_ready;
  assign bus.o_cfg_err   = cfg_err;
  assign bus.o_rx_tick   = rx_tick;
  assign bus.o_tx_tick   = tx_tick;
  assign bus.o_act_div   = act_div;
endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl: expected tick/error cycles are queued by the
// stimulus thread and matched by a negedge monitor.
module tb_baud_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   rx_q[$];
  int   tx_q[$];
  int   err_q[$];

  baud_ctrl_if #(.DIV_W(16), .OSR(16)) bus ();

  baud_ctrl #(.DIV_W(16), .DEFAULT_DIV(4), .OSR(16)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input string name, inout int q[$]);
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event at cycle %0d want none", name, cyc);
    end else begin
      check(name, cyc, q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_rx_tick === 1'b1) pop_check("rx_tick", rx_q);
    if (bus.o_tx_tick === 1'b1) pop_check("tx_tick", tx_q);
    if (bus.o_cfg_err === 1'b1) pop_check("cfg_err", err_q);
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_en(output int t0);
    @(negedge clk);
    t0 = cyc;
    bus.i_en = 1'b1;
  endtask

  task automatic stop_en(input int c);
    wait_cyc(c);
    bus.i_en = 1'b0;
  endtask

  task automatic send(input int c, input int div, input int frac);
    wait_cyc(c);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_div   = 16'(div);
`ifdef BAUD_CTRL_FRAC_EN
    bus.i_cfg_frac  = 4'(frac);
`else
    if (frac != 0) $display("note: frac ignored in this build");
`endif
    @(negedge clk);
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic push_ticks(inout int q[$], input int base, input int n, input int p);
    for (int k = 1; k <= n; k++) q.push_back(base + k * p);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check({name, "_rx_left"}, rx_q.size(), 0);
    check({name, "_tx_left"}, tx_q.size(), 0);
    check({name, "_err_left"}, err_q.size(), 0);
    rx_q.delete();
    tx_q.delete();
    err_q.delete();
  endtask

  initial begin
    int t0;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.i_en = 1'b0;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_div = '0;
`ifdef BAUD_CTRL_FRAC_EN
    bus.i_cfg_frac = '0;
`endif

    // 1: asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("rst_rx_tick", bus.o_rx_tick, 0);
    check("rst_tx_tick", bus.o_tx_tick, 0);
    check("rst_cfg_err", bus.o_cfg_err, 0);
    check("rst_act_div", bus.o_act_div, 4);
    check("rst_ready", bus.o_cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.o_cfg_ready, 1);

    // 2: default divisor 4 -> rx every 4, tx every 64
    start_en(t0);
    push_ticks(rx_q, t0, 17, 4);
    tx_q.push_back(t0 + 64);
    stop_en(t0 + 70);
    drain("default");

    // 3: divisor 10 loaded in IDLE
    send(cyc, 10, 0);
    check("idle_load_10", bus.o_act_div, 10);
    start_en(t0);
    push_ticks(rx_q, t0, 16, 10);
    tx_q.push_back(t0 + 160);
    stop_en(t0 + 165);
    drain("div10");

    // back to 4, then rejected requests while running
    send(cyc, 4, 0);
    check("idle_load_4", bus.o_act_div, 4);
    start_en(t0);
    push_ticks(rx_q, t0, 7, 4);
    err_q.push_back(t0 + 6);
    err_q.push_back(t0 + 11);
    send(t0 + 5, 1, 0);
    check("rej1_act_div", bus.o_act_div, 4);
    check("rej1_ready", bus.o_cfg_ready, 1);
    send(t0 + 10, 0, 0);
    check("rej0_act_div", bus.o_act_div, 4);
    check("rej0_ready", bus.o_cfg_ready, 1);
    stop_en(t0 + 30);
    drain("reject");

    // held invalid request in IDLE: one error per ready cycle
    @(negedge clk);
    err_q.push_back(cyc + 1);
    err_q.push_back(cyc + 2);
    bus.i_cfg_div = 16'd0;
    bus.i_cfg_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_cfg_valid = 1'b0;
    check("held_rej_act_div", bus.o_act_div, 4);
    drain("held_reject");

    // 4: change to 6 at the 5th rx tick, applied at the tx boundary
    start_en(t0);
    push_ticks(rx_q, t0, 16, 4);
    push_ticks(rx_q, t0 + 64, 17, 6);
    tx_q.push_back(t0 + 64);
    tx_q.push_back(t0 + 160);
    send(t0 + 20, 6, 0);
    check("pend_ready_low", bus.o_cfg_ready, 0);
    wait_cyc(t0 + 63);
    check("pend_old_div", bus.o_act_div, 4);
    check("pend_ready_still_low", bus.o_cfg_ready, 0);
    wait_cyc(t0 + 64);
    check("pend_new_div", bus.o_act_div, 6);
    check("pend_ready_back", bus.o_cfg_ready, 1);
    stop_en(t0 + 170);
    drain("pend6");

    // request accepted on the tx-tick edge goes to the following boundary
    send(cyc, 4, 0);
    start_en(t0);
    push_ticks(rx_q, t0, 32, 4);
    push_ticks(rx_q, t0 + 128, 17, 5);
    tx_q.push_back(t0 + 64);
    tx_q.push_back(t0 + 128);
    tx_q.push_back(t0 + 208);
    send(t0 + 63, 5, 0);
    check("edge_acc_ready", bus.o_cfg_ready, 0);
    check("edge_acc_div", bus.o_act_div, 4);
    wait_cyc(t0 + 127);
    check("edge_old_div", bus.o_act_div, 4);
    wait_cyc(t0 + 128);
    check("edge_new_div", bus.o_act_div, 5);
    stop_en(t0 + 215);
    drain("edge_tx");

    // disable while pending applies the pending divisor at once
    start_en(t0);
    send(t0 + 2, 7, 0);
    check("dis_pend_ready", bus.o_cfg_ready, 0);
    bus.i_en = 1'b0;
    @(negedge clk);
    check("dis_pend_div", bus.o_act_div, 7);
    check("dis_pend_ready_back", bus.o_cfg_ready, 1);
    drain("dis_pend");

    // reset while pending drops the request
    start_en(t0);
    send(t0 + 2, 9, 0);
    wait_cyc(t0 + 5);
    #2 rst = 1'b1;
    #1;
    check("rst_pend_div", bus.o_act_div, 4);
    check("rst_pend_ready", bus.o_cfg_ready, 1);
    bus.i_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_en(t0);
    push_ticks(rx_q, t0, 5, 4);
    stop_en(t0 + 22);
    drain("rst_pend");

`ifdef BAUD_CTRL_FRAC_EN
    // fractional: div 4, frac 3 -> periods 5,5,5 then 4 x13, tx 67
    send(cyc, 4, 3);
    start_en(t0);
    push_ticks(rx_q, t0, 3, 5);
    push_ticks(rx_q, t0 + 15, 13, 4);
    push_ticks(rx_q, t0 + 67, 2, 5);
    tx_q.push_back(t0 + 67);
    send(t0 + 78, 8, 1);
    check("frac_pend_ready", bus.o_cfg_ready, 0);
    wait_cyc(t0 + 80);
    #2 rst = 1'b1;
    #1;
    check("frac_rst_div", bus.o_act_div, 4);
    bus.i_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drain("frac");
    start_en(t0);
    push_ticks(rx_q, t0, 16, 4);
    tx_q.push_back(t0 + 64);
    stop_en(t0 + 66);
    drain("frac_cleared");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
